// File: rtl/pool1_pkg.sv
// Shared geometry, address widths and FSM state encoding for the pool1 row sequencer.
package pool1_pkg;
    localparam int NCH     = 20;
    localparam int IN_DIM  = 24;
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int RD_AW   = $clog2(NCH * IN_DIM);
    localparam int WR_AW   = $clog2(NCH * OUT_DIM);
    localparam int CH_W    = $clog2(NCH);
    localparam int ROW_W   = $clog2(OUT_DIM);

    typedef enum logic [2:0] {
        IDLE,
        RD_EVEN,
        WAIT_EVEN,
        RD_ODD,
        WAIT_ODD,
        WRITE,
        DONE
    } state_t;
endpackage

// File: rtl/pool_row_or.sv
// Combinational 2x2 binary max-pool of one row pair: each output bit ORs a 2x2 window.
module pool_row_or
    import pool1_pkg::*;
(
    input  logic [IN_DIM-1:0]  row_a,
    input  logic [IN_DIM-1:0]  row_b,
    output logic [OUT_DIM-1:0] pooled
);
    for (genvar k = 0; k < OUT_DIM; k++) begin : g_win
        assign pooled[k] = row_a[2*k] | row_a[2*k+1] | row_b[2*k] | row_b[2*k+1];
    end
endmodule

// File: rtl/pool1_seq.sv
// Time-multiplexed sequencer for the first max-pool layer: reads row pairs,
// pools them and writes one output row per pair, channel-major.
module pool1_seq
    import pool1_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               rd_req,
    output logic [RD_AW-1:0]   rd_addr,
    input  logic               rd_valid,
    input  logic [IN_DIM-1:0]  rd_data,
    output logic               wr_en,
    output logic [WR_AW-1:0]   wr_addr,
    output logic [OUT_DIM-1:0] wr_data,
    input  logic               wr_ready
);
    state_t              state, state_nxt;
    logic [CH_W-1:0]     ch;
    logic [ROW_W-1:0]    orow;
    logic [IN_DIM-1:0]   row_a, row_b;
    logic [OUT_DIM-1:0]  pooled;
    logic [RD_AW-1:0]    row_base;
    logic                last_row, wr_acc;

    assign last_row = (ch == CH_W'(NCH - 1)) && (orow == ROW_W'(OUT_DIM - 1));
    assign wr_acc   = (state == WRITE) && wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Counters hold at the last row after the final write; a new start rewinds them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch    <= '0;
            orow  <= '0;
            row_a <= '0;
            row_b <= '0;
        end else begin
            if (state == IDLE && start) begin
                ch   <= '0;
                orow <= '0;
            end
            if (state == WAIT_EVEN && rd_valid) row_a <= rd_data;
            if (state == WAIT_ODD  && rd_valid) row_b <= rd_data;
            if (wr_acc && !last_row) begin
                if (orow == ROW_W'(OUT_DIM - 1)) begin
                    orow <= '0;
                    ch   <= ch + 1'b1;
                end else begin
                    orow <= orow + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_req    = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE:      if (start) state_nxt = RD_EVEN;
            RD_EVEN: begin
                busy      = 1'b1;
                rd_req    = 1'b1;
                state_nxt = WAIT_EVEN;
            end
            WAIT_EVEN: begin
                busy = 1'b1;
                if (rd_valid) state_nxt = RD_ODD;
            end
            RD_ODD: begin
                busy      = 1'b1;
                rd_req    = 1'b1;
                state_nxt = WAIT_ODD;
            end
            WAIT_ODD: begin
                busy = 1'b1;
                if (rd_valid) state_nxt = WRITE;
            end
            WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (wr_ready) state_nxt = last_row ? DONE : RD_EVEN;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    pool_row_or u_pool (
        .row_a  (row_a),
        .row_b  (row_b),
        .pooled (pooled)
    );

    assign row_base = RD_AW'(ch) * RD_AW'(IN_DIM) + RD_AW'({orow, 1'b0});
    assign rd_addr  = rd_req ? row_base + RD_AW'(state == RD_ODD) : '0;
    assign wr_addr  = wr_en ? WR_AW'(ch) * WR_AW'(OUT_DIM) + WR_AW'(orow) : '0;
    assign wr_data  = wr_en ? pooled : '0;
endmodule

// File: tb/tb_pool1_seq.sv
// Self-checking bench for pool1_seq: memory responder with variable latency,
// backpressure, spurious stimulus, golden OR-pool model and table vectors.
module tb_pool1_seq;
    import pool1_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               busy, done, rd_req, wr_en;
    logic [RD_AW-1:0]   rd_addr;
    logic [WR_AW-1:0]   wr_addr;
    logic [OUT_DIM-1:0] wr_data;
    logic               rd_valid = 1'b0;
    logic [IN_DIM-1:0]  rd_data = '0;
    logic               wr_ready = 1'b0;

    always #5 clk = ~clk;

    pool1_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready)
    );

    typedef struct {
        logic [IN_DIM-1:0]  row_a;
        logic [IN_DIM-1:0]  row_b;
        logic [OUT_DIM-1:0] exp;
    } vec_t;
    vec_t tbl [10];

    logic [IN_DIM-1:0]  mem [NCH*IN_DIM];
    logic [OUT_DIM-1:0] got [NCH*OUT_DIM];

    int vecs = 0, errs = 0;
    int cyc = 0, start_cyc = 0;
    bit rand_lat = 0, bp = 0, spur = 0, illegal = 0;
    int reads = 0, writes = 0, dones = 0;
    int first_wr = -1, last_wr = -1, done_at = -1;
    int pend = 0, pend_addr = 0, wst = 0;
    bit stalled = 0;
    logic [WR_AW-1:0]   s_addr;
    logic [OUT_DIM-1:0] s_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Output bit k is set when any of the four window bits (2k, 2k+1 of both rows) is set.
    function automatic logic [OUT_DIM-1:0] golden(int wa);
        int base;
        logic [IN_DIM-1:0]  a, b;
        logic [OUT_DIM-1:0] r;
        base = (wa / OUT_DIM) * IN_DIM + 2 * (wa % OUT_DIM);
        a = mem[base];
        b = mem[base + 1];
        r = '0;
        for (int k = 0; k < OUT_DIM; k++)
            r[k] = (((a >> (2*k)) & 24'd3) != 0) || (((b >> (2*k)) & 24'd3) != 0);
        return r;
    endfunction

    // Memory responder and write sink; all DUT inputs except start/rst_n are driven here.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend     = 0;
            wst      = 0;
            stalled  = 0;
            rd_valid = 1'b0;
            wr_ready = 1'b0;
        end else begin
            rd_valid = 1'b0;
            rd_data  = IN_DIM'($urandom);
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    rd_valid = 1'b1;
                    rd_data  = mem[pend_addr];
                end
            end
            if (rd_req) begin
                check("rd_outstanding", pend, 0);
                check("rd_addr", 32'(rd_addr), reads);
                pend_addr = int'(rd_addr);
                pend      = rand_lat ? int'($urandom_range(7, 1)) : 1;
                reads++;
                if (spur) rd_valid = 1'b1;
            end
            if (wr_en) begin
                if (stalled) begin
                    check("wr_addr_stable", 32'(wr_addr), 32'(s_addr));
                    check("wr_data_stable", 32'(wr_data), 32'(s_data));
                end
                if (bp && wst < 3) begin
                    wr_ready = 1'b0;
                    wst++;
                    stalled = 1;
                    s_addr  = wr_addr;
                    s_data  = wr_data;
                end else begin
                    wr_ready = 1'b1;
                    wst      = 0;
                    stalled  = 0;
                    check("wr_addr", 32'(wr_addr), writes);
                    if (writes < NCH*OUT_DIM) begin
                        check("wr_data", 32'(wr_data), 32'(golden(writes)));
                        got[writes] = wr_data;
                    end else begin
                        check("wr_extra", writes, NCH*OUT_DIM - 1);
                    end
                    if (first_wr < 0) first_wr = cyc - start_cyc;
                    last_wr = cyc - start_cyc;
                    writes++;
                end
                if (spur) rd_valid = 1'b1;
            end else begin
                wr_ready = !bp;
            end
            if (done) begin
                dones++;
                done_at = cyc - start_cyc;
            end
        end
    end

    task automatic begin_pass();
        @(negedge clk); #1;
        reads = 0; writes = 0; dones = 0;
        first_wr = -1; last_wr = -1; done_at = -1;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        check("busy_cycle1", busy, 1);
    endtask

    task automatic wait_done(string tag);
        int n = 0;
        forever begin
            @(negedge clk); #1;
            n++;
            if (done || n >= 20000) break;
            start = illegal && (n % 37 == 3);
        end
        check({tag, "_timeout"}, n < 20000, 1);
        // a start presented during DONE must not launch a new pass
        start = illegal;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic end_pass(string tag, bit ideal);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_writes"}, writes, NCH*OUT_DIM);
        check({tag, "_reads"}, reads, NCH*IN_DIM);
        check({tag, "_dones"}, dones, 1);
        check({tag, "_busy_after"}, busy, 0);
        if (ideal) begin
            check({tag, "_first_wr_cyc"}, first_wr, 5);
            check({tag, "_last_wr_cyc"}, last_wr, 1200);
            check({tag, "_done_cyc"}, done_at, 1201);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NCH*IN_DIM; i++) mem[i] = IN_DIM'($urandom);
    endtask

    initial begin
        int n;
        tbl[0] = '{24'h000001, 24'h800000, 12'h801};
        tbl[1] = '{24'h000000, 24'h000000, 12'h000};
        tbl[2] = '{24'hFFFFFF, 24'h000000, 12'hFFF};
        tbl[3] = '{24'h000000, 24'hFFFFFF, 12'hFFF};
        tbl[4] = '{24'h555555, 24'h000000, 12'hFFF};
        tbl[5] = '{24'h000000, 24'hAAAAAA, 12'hFFF};
        tbl[6] = '{24'h000003, 24'h00000C, 12'h003};
        tbl[7] = '{24'h100000, 24'h000010, 12'h404};
        tbl[8] = '{24'hC00000, 24'h000000, 12'h800};
        tbl[9] = '{24'h030000, 24'h000000, 12'h100};

        // reset and idle
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        repeat (20) @(negedge clk);
        #1;
        check("idle_reads", reads, 0);
        check("idle_writes", writes, 0);
        check("idle_busy", busy, 0);

        // all-zero input, ideal timing
        for (int i = 0; i < NCH*IN_DIM; i++) mem[i] = '0;
        begin_pass();
        wait_done("zero");
        end_pass("zero", 1);

        // table vectors in ch0 rows, random elsewhere
        fill_random();
        for (int i = 0; i < 10; i++) begin
            mem[2*i]     = tbl[i].row_a;
            mem[2*i + 1] = tbl[i].row_b;
        end
        begin_pass();
        wait_done("table");
        end_pass("table", 1);
        for (int i = 0; i < 10; i++) check($sformatf("tbl%0d", i), 32'(got[i]), 32'(tbl[i].exp));

        // random latency, backpressure, spurious rd_valid, illegal starts
        fill_random();
        rand_lat = 1; bp = 1; spur = 1; illegal = 1;
        begin_pass();
        wait_done("stress");
        end_pass("stress", 0);
        rand_lat = 0; bp = 0; spur = 0; illegal = 0;

        // reset after 100 writes, then a clean full pass
        fill_random();
        begin_pass();
        n = 0;
        while (writes < 100 && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        check("mid_reach_100", n < 5000, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_req", rd_req, 0);
        check("mid_rst_wr_en", wr_en, 0);
        repeat (5) @(negedge clk);
        #1;
        check("mid_rst_no_done", dones, 0);
        check("mid_rst_writes", writes, 100);
        rst_n = 1'b1;
        begin_pass();
        wait_done("after_rst");
        end_pass("after_rst", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
